bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//   Sequential decimal-to-binary converter; the inverse of the LED path's binary-to-decimal splitter.
//   Takes NUM_DIGITS packed BCD digits and produces their unsigned binary value.
//   Method: iterative acc = acc*10 + digit, MSD first, one digit per clock.
//   Used where decimal entry (switch/keypad digits) must reach the CPU as a binary word.
// PARAMETERS
//   NUM_DIGITS  8   number of BCD digits in bcd_in (>=1)
//   OUT_W       32  width of binary_out and of the internal accumulator
// PORTS
//   clk         in   1             system clock, rising edge
//   rst         in   1             asynchronous, active-high reset
//   start       in   1             request; sampled only in IDLE
//   bcd_in      in   4*NUM_DIGITS  digit k in bits [4k+3:4k]; digit 0 = least significant
//   busy        out  1             high while converting
//   done        out  1             one-cycle completion pulse
//   err         out  1             invalid digit seen in last conversion (BCD_ERR_CHECK_EN only)
//   binary_out  out  OUT_W         result of last completed conversion
// BEHAVIOUR
//   - Reset (async, any time incl. mid-conversion): state=IDLE, busy=0, done=0, err=0,
//     binary_out=0, acc=0, digit counter=0. Any conversion in progress is discarded.
//   - FSM states: IDLE, CONV.
//   - IDLE, start=1 at edge T0:
//     - latch bcd_in into a shift register (later bcd_in changes ignored); acc=0, cnt=0
//     - err=0, busy=1, go CONV
//   - CONV: at each edge T1..T(NUM_DIGITS), take the current MSD d of the shift register:
//     - acc = (acc*10 + d) mod 2^OUT_W; shift register left by 4; cnt++
//   - At edge T(NUM_DIGITS): binary_out = final acc; done=1 for exactly one cycle;
//     busy=0; go IDLE.
//     - Latency: done high in the cycle after edge T0+NUM_DIGITS.
//   - Outputs: done is registered and otherwise 0.
//     - binary_out changes only on completion (or reset) and holds until the next completion.
//   - start while busy: ignored, no queuing.
//   - start in the cycle done is high: accepted (state is IDLE); begins a new conversion.
//   - start held high: a new conversion starts every NUM_DIGITS+1 cycles.
//   - Arithmetic: acc*10 formed as (acc<<3)+(acc<<1) at OUT_W bits, truncated.
//     - No overflow flag; default sizing (max 99999999 < 2^27) never wraps.
// CONFIGURATION
//   BCD_ERR_CHECK_EN defined:
//     - a digit > 9 at the edge it is consumed aborts the conversion: err=1, done=1 (one cycle),
//       busy=0, state=IDLE, binary_out=0.
//     - err holds until the next accepted start or reset.
//   BCD_ERR_CHECK_EN undefined:
//     - no check; digits 10..15 are used at face value in acc*10+d; err tied to 0.
// TESTING
//   1. bcd_in=32'h12345678, start 1 cycle -> busy 8 cycles; done 8 cycles after start edge;
//      binary_out=32'h00BC614E; err=0.
//   2. bcd_in=32'h99999999 -> binary_out=32'h05F5E0FF.
//      bcd_in=32'h00000000 -> binary_out=0, done still pulses.
//   3. Pulse start again at cycle 3 of a conversion with a different bcd_in -> ignored;
//      result is that of the first request; one done pulse only.
//   4. Hold start high with bcd_in=32'h00000042 -> done every 9 cycles, binary_out=32'h0000002A each time.
//   5. bcd_in=32'h0000000A:
//      - with BCD_ERR_CHECK_EN -> at 8th edge err=1, done=1, binary_out=0.
//      - without -> binary_out=32'h0000000A, err=0.
//   6. Assert rst at cycle 4 of a conversion -> all outputs 0 immediately, no done pulse;
//      a following start converts normally.

Source files
------------

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to unsigned binary converter.
// Consumes one digit per clock, most significant digit first: acc = acc*10 + digit.
// Optional feature macro: BCD_ERR_CHECK_EN aborts a conversion on a digit above 9 and flags err.
module bcd_to_binary #(
    parameter int NUM_DIGITS = 8,
    parameter int OUT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [OUT_W-1:0]        binary_out
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]              r_state;
    logic [4*NUM_DIGITS-1:0] r_shift;
    logic [OUT_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_done;
    logic                    r_err;
    logic [OUT_W-1:0]        r_binary;

    logic [3:0]              w_digit;
    logic [OUT_W-1:0]        w_acc_next;
    logic                    w_last;
    logic                    w_bad;

    // Current most significant digit still waiting in the shift register.
    assign w_digit    = r_shift[4*NUM_DIGITS-1 -: 4];
    // acc*10 built from two shifts; wraps silently at OUT_W bits.
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_digit);
    assign w_last     = (r_cnt == LAST_CNT);

`ifdef BCD_ERR_CHECK_EN
    assign w_bad = (w_digit > 4'd9);
`else
    // Digits 10..15 are accepted at face value.
    assign w_bad = 1'b0;
`endif

    assign busy       = (r_state == S_CONV);
    assign done       = r_done;
    assign err        = r_err;
    assign binary_out = r_binary;

    // Conversion FSM: latch on start in IDLE, then fold one digit per clock into the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_binary <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (w_bad) begin
                        // Abort: report the error through the normal completion pulse.
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_binary <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_shift <= r_shift << 4;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_binary <= w_acc_next;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: a driver pushes the expected outcome of every
// accepted request into a queue; a monitor pops it whenever done is seen and compares.
module tb_bcd_to_binary;

    localparam int N = 8;

    typedef struct {
        logic [31:0] val;
        logic        err;
        int          start_edge;
        int          done_edge;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] binary_out;

    int          checks   = 0;
    int          errors   = 0;
    int          edge_cnt = 0;
    int          m_free   = 0;
    logic [31:0] m_last   = '0;
    logic        m_err    = 1'b0;
    exp_t        q[$];

    bcd_to_binary #(
        .NUM_DIGITS(N),
        .OUT_W     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .binary_out(binary_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_cnt);
        end
    endfunction

    // Reference: decimal value of the digits, MSD first, with 32-bit wrap.
    function automatic exp_t model(logic [31:0] bcd, int e);
        exp_t        r;
        logic [31:0] acc;
        logic [31:0] d;
        acc          = '0;
        r.err        = 1'b0;
        r.val        = '0;
        r.start_edge = e;
        r.done_edge  = e + N;
        for (int j = 1; j <= N; j++) begin
            d = (bcd >> (4 * (N - j))) & 32'hF;
`ifdef BCD_ERR_CHECK_EN
            if (d > 9) begin
                r.err       = 1'b1;
                r.val       = '0;
                r.done_edge = e + j;
                return r;
            end
`endif
            acc = acc * 10 + d;
        end
        r.val = acc;
        return r;
    endfunction

    // One clock of stimulus; a start is accepted only once the previous request has finished.
    task automatic cyc(input logic s, input logic [31:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        start  = s;
        bcd_in = b;
        if (s && (edge_cnt + 1) >= m_free) begin
            e = model(b, edge_cnt + 1);
            q.push_back(e);
            m_free = e.done_edge + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, bcd_in);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        q.delete();
        m_last = '0;
        m_err  = 1'b0;
        m_free = 0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_binary_out", binary_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops on done, flags missing/unexpected pulses, checks busy and held outputs.
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_edge", edge_cnt, e.done_edge);
                    check("result", binary_out, e.val);
                    check("err_flag", {31'b0, err}, {31'b0, e.err});
                    m_last = e.val;
                    m_err  = e.err;
                end
            end else if (q.size() > 0 && q[0].done_edge <= edge_cnt) begin
                e = q.pop_front();
                check("missing_done", 32'd0, 32'd1);
                m_last = e.val;
                m_err  = e.err;
            end
            if (q.size() > 0 && q[0].start_edge <= edge_cnt) m_err = 1'b0;
            exp_busy = (q.size() > 0 && q[0].start_edge <= edge_cnt && edge_cnt < q[0].done_edge);
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("hold_binary_out", binary_out, m_last);
            check("hold_err", {31'b0, err}, {31'b0, m_err});
        end
    end

    initial begin
        logic [31:0] b;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("init_busy", {31'b0, busy}, 32'd0);
        check("init_done", {31'b0, done}, 32'd0);
        check("init_binary_out", binary_out, 32'd0);
        rst = 1'b0;

        // Basic conversions.
        cyc(1'b1, 32'h12345678);
        idle(11);
        check("t1_const", binary_out, 32'h00BC614E);
        cyc(1'b1, 32'h99999999);
        idle(11);
        check("t2_max", binary_out, 32'h05F5E0FF);
        cyc(1'b1, 32'h00000000);
        idle(11);

        // Start during a conversion is ignored.
        cyc(1'b1, 32'h12345678);
        cyc(1'b0, 32'h87654321);
        cyc(1'b0, 32'h87654321);
        cyc(1'b1, 32'h87654321);
        cyc(1'b0, 32'h87654321);
        idle(10);
        check("t3_first_wins", binary_out, 32'h00BC614E);

        // Start held high: back-to-back conversions.
        for (int i = 0; i < 30; i++) cyc(1'b1, 32'h00000042);
        cyc(1'b0, 32'h0);
        idle(10);
        check("t4_held", binary_out, 32'h0000002A);

        // Non-decimal digit.
        cyc(1'b1, 32'h0000000A);
        idle(11);
`ifdef BCD_ERR_CHECK_EN
        check("t5_err_out", binary_out, 32'h0);
        check("t5_err_flag", {31'b0, err}, 32'd1);
`else
        check("t5_face_value", binary_out, 32'h0000000A);
        check("t5_no_err", {31'b0, err}, 32'd0);
`endif

        // Reset mid-conversion, then a normal conversion.
        cyc(1'b1, 32'h00000777);
        idle(3);
        do_reset();
        cyc(1'b1, 32'h00004321);
        idle(11);
        check("t6_after_rst", binary_out, 32'h000010E1);

        // Random traffic: mixed valid and arbitrary nibbles, start at random times.
        for (int i = 0; i < 400; i++) begin
            b = $urandom();
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < N; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            cyc(1'($urandom_range(0, 2) == 0), b);
        end
        cyc(1'b0, 32'h0);
        idle(12);
        check("drain", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
